// File: rtl/pwm_duty_meas.sv
// Monitors one H-bridge PWM pair: recovers the PWM1 high time per period as a duty
// value and a signed speed command, and flags shoot-through, period errors and stuck lines.
module pwm_duty_meas #(
  parameter int PERIOD  = 4096,
  parameter int TIMEOUT = 8192,
  parameter bit INV     = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               PWM1,
  input  logic               PWM2,
  input  logic               clr_err,
  output logic [11:0]        duty,
  output logic signed [11:0] spd,
  output logic               dty_vld,
  output logic               shoot_thru,
  output logic               per_err,
  output logic               stuck
);

  localparam logic [13:0] PERIOD_C  = 14'(PERIOD);
  localparam logic [13:0] TIMEOUT_C = 14'(TIMEOUT);
  localparam logic [13:0] PER_MAX   = 14'h3FFF;
  localparam logic [11:0] HI_MAX    = 12'hFFF;

  // SYNC: no complete period seen yet; MEAS: measuring between PWM1 rising edges.
  typedef enum logic {
    SYNC = 1'b0,
    MEAS = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic               p1_m_q, p1_s_q, p1_d_q;
  logic               p2_m_q, p2_s_q;
  logic [11:0]        hi_cnt_q, hi_cnt_d;
  logic [13:0]        per_cnt_q, per_cnt_d;
  logic [11:0]        duty_q, duty_d;
  logic signed [11:0] spd_q, spd_d;
  logic               dty_vld_q, dty_vld_d;
  logic               shoot_thru_q, shoot_thru_d;
  logic               per_err_q, per_err_d;
  logic               stuck_q, stuck_d;

  logic               rise;
  logic               timeout;
  logic               per_set;
  logic [13:0]        per_inc;
  logic [11:0]        hi_inc;
  logic signed [12:0] spd_inv;

  assign rise    = p1_s_q & ~p1_d_q;
  assign timeout = (per_cnt_q == TIMEOUT_C);
  assign per_inc = (per_cnt_q == PER_MAX) ? per_cnt_q : per_cnt_q + 14'd1;
  assign hi_inc  = (hi_cnt_q == HI_MAX) ? hi_cnt_q : hi_cnt_q + {11'd0, p1_s_q};

  always_comb begin
    state_d   = state_q;
    hi_cnt_d  = hi_cnt_q;
    per_cnt_d = per_cnt_q;
    duty_d    = duty_q;
    dty_vld_d = 1'b0;
    stuck_d   = stuck_q;
    per_set   = 1'b0;
    unique case (state_q)
      SYNC: begin
        // The first rise only opens a period; a partial period is never reported.
        if (rise) begin
          state_d   = MEAS;
          hi_cnt_d  = 12'd1;
          per_cnt_d = 14'd1;
        end else if (timeout) begin
          duty_d    = p1_s_q ? 12'hFFF : 12'h000;
          dty_vld_d = 1'b1;
          stuck_d   = 1'b1;
          hi_cnt_d  = 12'd0;
          per_cnt_d = 14'd1;
        end else begin
          hi_cnt_d  = 12'd0;
          per_cnt_d = per_inc;
        end
      end
      MEAS: begin
        // A rise on the timeout cycle still counts as a normal period end.
        if (rise) begin
          duty_d    = hi_cnt_q;
          dty_vld_d = 1'b1;
          stuck_d   = 1'b0;
          per_set   = (per_cnt_q != PERIOD_C);
          hi_cnt_d  = 12'd1;
          per_cnt_d = 14'd1;
        end else if (timeout) begin
          duty_d    = p1_s_q ? 12'hFFF : 12'h000;
          dty_vld_d = 1'b1;
          stuck_d   = 1'b1;
          hi_cnt_d  = 12'd0;
          per_cnt_d = 14'd1;
        end else begin
          hi_cnt_d  = hi_inc;
          per_cnt_d = per_inc;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  always_comb begin
    spd_inv = 13'sd2048 - $signed({1'b0, duty_d});
    spd_d   = $signed(duty_d - 12'h800);
    if (INV) begin
      // 0x800 - 0x000 would be +2048, which does not fit; clamp it.
      if (spd_inv > 13'sd2047) begin
        spd_d = 12'sh7FF;
      end else if (spd_inv < -13'sd2048) begin
        spd_d = 12'sh800;
      end else begin
        spd_d = spd_inv[11:0];
      end
    end
  end

  // Sticky flags: a set in the same cycle as clr_err wins.
  always_comb begin
    shoot_thru_d = shoot_thru_q;
    per_err_d    = per_err_q;
    if (p1_s_q & p2_s_q) begin
      shoot_thru_d = 1'b1;
    end else if (clr_err) begin
      shoot_thru_d = 1'b0;
    end
    if (per_set) begin
      per_err_d = 1'b1;
    end else if (clr_err) begin
      per_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_m_q       <= 1'b0;
      p1_s_q       <= 1'b0;
      p1_d_q       <= 1'b0;
      p2_m_q       <= 1'b0;
      p2_s_q       <= 1'b0;
      state_q      <= SYNC;
      hi_cnt_q     <= 12'd0;
      per_cnt_q    <= 14'd0;
      duty_q       <= 12'h800;
      spd_q        <= 12'sd0;
      dty_vld_q    <= 1'b0;
      shoot_thru_q <= 1'b0;
      per_err_q    <= 1'b0;
      stuck_q      <= 1'b0;
    end else begin
      p1_m_q       <= PWM1;
      p1_s_q       <= p1_m_q;
      p1_d_q       <= p1_s_q;
      p2_m_q       <= PWM2;
      p2_s_q       <= p2_m_q;
      state_q      <= state_d;
      hi_cnt_q     <= hi_cnt_d;
      per_cnt_q    <= per_cnt_d;
      duty_q       <= duty_d;
      spd_q        <= spd_d;
      dty_vld_q    <= dty_vld_d;
      shoot_thru_q <= shoot_thru_d;
      per_err_q    <= per_err_d;
      stuck_q      <= stuck_d;
    end
  end

  assign duty       = duty_q;
  assign spd        = spd_q;
  assign dty_vld    = dty_vld_q;
  assign shoot_thru = shoot_thru_q;
  assign per_err    = per_err_q;
  assign stuck      = stuck_q;

endmodule

// File: tb/tb_pwm_duty_meas.sv
// Bench for pwm_duty_meas: random and directed PWM waveforms against a period-level
// reference model, with one instance per speed-mapping convention.
module tb_pwm_duty_meas;

  localparam int PERIOD  = 4096;
  localparam int TIMEOUT = 8192;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pwm1 = 1'b0;
  logic        pwm2 = 1'b1;
  logic        clr_err = 1'b0;
  logic [11:0] duty0, duty1, spd0, spd1;
  logic        dv0, dv1, sh0, sh1, pe0, pe1, st0, st1;

  pwm_duty_meas #(.PERIOD(PERIOD), .TIMEOUT(TIMEOUT), .INV(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .PWM1(pwm1), .PWM2(pwm2), .clr_err(clr_err),
    .duty(duty0), .spd(spd0), .dty_vld(dv0), .shoot_thru(sh0), .per_err(pe0), .stuck(st0)
  );

  pwm_duty_meas #(.PERIOD(PERIOD), .TIMEOUT(TIMEOUT), .INV(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .PWM1(pwm1), .PWM2(pwm2), .clr_err(clr_err),
    .duty(duty1), .spd(spd1), .dty_vld(dv1), .shoot_thru(sh1), .per_err(pe1), .stuck(st1)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  function automatic logic [11:0] spd_of(input int d, input bit inv);
    int v;
    v = inv ? (2048 - d) : (d - 2048);
    if (v > 2047) v = 2047;
    if (v < -2048) v = -2048;
    return v[11:0];
  endfunction

  // ---------------- reference model ----------------
  // Works on the PWM1/PWM2 samples taken at each clock edge; a level change is
  // seen by the measurement logic two edges after it is sampled.
  bit [2:0]    p1_h = 3'b000;
  bit [2:0]    p2_h = 3'b000;
  bit          m_sync = 1'b1;
  int          m_elapsed = 0;
  bit          seg_q[$];
  int          m_duty = 2048;
  bit          m_vld = 1'b0, m_shoot = 1'b0, m_perr = 1'b0, m_stuck = 1'b0;
  logic [11:0] exp_q[$];

  task automatic model_reset();
    p1_h = 3'b000;
    p2_h = 3'b000;
    m_sync = 1'b1;
    m_elapsed = 0;
    seg_q.delete();
    m_duty = 2048;
    m_vld = 1'b0;
    m_shoot = 1'b0;
    m_perr = 1'b0;
    m_stuck = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step(input bit s1, input bit s2, input bit clr);
    bit a1, a0, b1, rise, pset;
    int ones;
    a1 = p1_h[1];
    a0 = p1_h[2];
    b1 = p2_h[1];
    rise = a1 && !a0;
    pset = 1'b0;
    m_vld = 1'b0;
    if (rise) begin
      if (!m_sync) begin
        ones = 0;
        foreach (seg_q[i]) ones += int'(seg_q[i]);
        m_duty  = (ones > 4095) ? 4095 : ones;
        m_vld   = 1'b1;
        m_stuck = 1'b0;
        pset    = (m_elapsed != PERIOD);
      end
      m_sync = 1'b0;
      seg_q.delete();
      seg_q.push_back(1'b1);
      m_elapsed = 1;
    end else if (m_elapsed == TIMEOUT) begin
      m_duty  = a1 ? 4095 : 0;
      m_vld   = 1'b1;
      m_stuck = 1'b1;
      seg_q.delete();
      m_elapsed = 1;
    end else begin
      if (m_elapsed < 16383) m_elapsed++;
      if (!m_sync) seg_q.push_back(a1);
    end
    if (m_vld) exp_q.push_back(m_duty[11:0]);
    if (a1 && b1) m_shoot = 1'b1;
    else if (clr) m_shoot = 1'b0;
    if (pset) m_perr = 1'b1;
    else if (clr) m_perr = 1'b0;
    p1_h = {p1_h[1:0], s1};
    p2_h = {p2_h[1:0], s2};
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else model_step(pwm1, pwm2, clr_err);
  end

  // ---------------- compare / scoreboard ----------------
  int          vld_cnt = 0;
  logic [11:0] got_duty[$];
  logic [11:0] got_spd[$];

  always @(negedge clk) begin
    if (chk_en) begin
      check("duty", duty0, m_duty);
      check("duty_inv", duty1, m_duty);
      check("spd", spd0, spd_of(m_duty, 1'b0));
      check("spd_inv", spd1, spd_of(m_duty, 1'b1));
      check("dty_vld", dv0, m_vld);
      check("dty_vld_inv", dv1, m_vld);
      check("shoot_thru", sh0, m_shoot);
      check("per_err", pe0, m_perr);
      check("stuck", st0, m_stuck);
      check("flags_inv", {sh1, pe1, st1}, {m_shoot, m_perr, m_stuck});
      if (dv0) begin
        vld_cnt++;
        got_duty.push_back(duty0);
        got_spd.push_back(spd0);
        if (exp_q.size() == 0) check("sb_unexpected_vld", 1, 0);
        else check("sb_duty", duty0, exp_q.pop_front());
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic drive_period(input int per, input int hi, input int clr_c);
    for (int c = 0; c < per; c++) begin
      @(posedge clk);
      #2;
      pwm1 = (c < hi);
      pwm2 = !(c < hi);
      clr_err = (c == clr_c);
    end
  endtask

  task automatic hold(input int n, input bit lvl);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #2;
      pwm1 = lvl;
      pwm2 = !lvl;
      clr_err = 1'b0;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_duty"}, duty0, 12'h800);
    check({tag, "_spd"}, spd0, 12'h000);
    check({tag, "_spd_inv"}, spd1, 12'h000);
    check({tag, "_vld"}, dv0, 1'b0);
    check({tag, "_shoot"}, sh0, 1'b0);
    check({tag, "_per_err"}, pe0, 1'b0);
    check({tag, "_stuck"}, st0, 1'b0);
  endtask

  task automatic do_reset(input bit lvl);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    pwm1 = lvl;
    pwm2 = !lvl;
    clr_err = 1'b0;
    @(negedge clk);
    check_reset_vals("rst");
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check_reset_vals("init");
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // 1024/4096 PWM: the first rise opens the measurement, then one report per period.
    vld_cnt = 0;
    repeat (3) drive_period(PERIOD, 1024, -1);
    @(negedge clk);
    check("p1_vld_count", vld_cnt, 2);
    check("p1_duty", duty0, 12'h400);
    check("p1_spd", spd0, 12'hC00);
    check("p1_spd_inv", spd1, 12'h400);
    check("p1_per_err", pe0, 1'b0);

    // Duty sweep around mid-scale, then random duty at the nominal period.
    got_duty.delete();
    got_spd.delete();
    drive_period(PERIOD, 2048, -1);
    drive_period(PERIOD, 2047, -1);
    drive_period(PERIOD, 2049, -1);
    repeat (2) drive_period(PERIOD, int'($urandom_range(1, 4095)), -1);
    @(negedge clk);
    check("sweep_reports", got_spd.size(), 5);
    if (got_spd.size() >= 4) begin
      check("sweep_duty_800", got_duty[1], 12'h800);
      check("sweep_spd_0", got_spd[1], 12'h000);
      check("sweep_spd_m1", got_spd[2], 12'hFFF);
      check("sweep_spd_p1", got_spd[3], 12'h001);
    end
    check("sweep_per_err", pe0, 1'b0);

    // Short periods: clr_err on the reporting edge loses, on a quiet cycle it clears.
    drive_period(4000, int'($urandom_range(1, 3999)), -1);
    drive_period(4000, 1000, 2);
    @(negedge clk);
    check("perr_set_wins", pe0, 1'b1);
    drive_period(PERIOD, 2048, 500);
    @(negedge clk);
    check("perr_quiet_clear", pe0, 1'b0);

    // One-cycle overlap of PWM1 and PWM2.
    @(posedge clk);
    #2;
    pwm1 = 1'b1;
    pwm2 = 1'b1;
    @(posedge clk);
    #2;
    pwm2 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("shoot_3cyc", sh0, 1'b1);
    drive_period(1500, 700, -1);
    @(negedge clk);
    check("shoot_sticky", sh0, 1'b1);

    // Reset mid-period: the first report needs two fresh rises.
    do_reset(1'b0);
    vld_cnt = 0;
    drive_period(PERIOD, 3000, -1);
    @(negedge clk);
    check("rst_no_vld_1rise", vld_cnt, 0);
    drive_period(PERIOD, 3000, -1);
    @(negedge clk);
    check("rst_vld_2rise", vld_cnt, 1);
    check("rst_duty", duty0, 12'hBB8);
    check("rst_spd", spd0, 12'h3B8);

    // PWM1 stuck high after reset: repeated timeout reports.
    do_reset(1'b1);
    vld_cnt = 0;
    hold(TIMEOUT + 20, 1'b1);
    @(negedge clk);
    check("hi_vld_count", vld_cnt, 1);
    check("hi_duty", duty0, 12'hFFF);
    check("hi_stuck", st0, 1'b1);
    check("hi_spd", spd0, 12'h7FF);
    check("hi_spd_inv", spd1, 12'h801);
    hold(TIMEOUT, 1'b1);
    @(negedge clk);
    check("hi_repeat_count", vld_cnt, 2);

    // PWM1 stuck low after reset.
    do_reset(1'b0);
    vld_cnt = 0;
    hold(TIMEOUT + 20, 1'b0);
    @(negedge clk);
    check("lo_vld_count", vld_cnt, 1);
    check("lo_duty", duty0, 12'h000);
    check("lo_stuck", st0, 1'b1);
    check("lo_spd", spd0, 12'h800);
    check("lo_spd_inv", spd1, 12'h7FF);

    chk_en = 1'b0;
    check("sb_leftover", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
